// File: rtl/alu_pkg.sv
// Shared constants for the nibble-serial ALU sequencer.
// Control codes, FSM encoding and slice width.
package alu_pkg;

  localparam int SLICE_W = 4;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ops whose carry chain is meaningful.
  function automatic logic is_arith(input logic [3:0] c);
    return (c == ALU_ADD) || (c == ALU_SUB) || (c == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_4.sv
// Classic 4-bit ALU slice: optional operand inversion,
// AND / OR / ADD / LESS selected by op, ripple carry out.
module alu_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic       less_i,
  input  logic [1:0] op_i,
  output logic [3:0] result_o,
  output logic       cout_o
);

  logic [3:0] aa;
  logic [3:0] bb;
  logic [4:0] sum;

  // Invert, add, and select the operation output.
  always_comb begin
    aa       = a_i ^ {4{a_invert_i}};
    bb       = b_i ^ {4{b_invert_i}};
    sum      = {1'b0, aa} + {1'b0, bb} + {4'b0, cin_i};
    cout_o   = sum[4];
    result_o = '0;
    unique case (op_i)
      2'b00:   result_o = aa & bb;
      2'b01:   result_o = aa | bb;
      2'b10:   result_o = sum[3:0];
      default: result_o = {3'b000, less_i};
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs a WIDTH-bit ALU op through one 4-bit slice,
// low nibble first, then reports result and flags.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = $clog2(NSLICE + 1);
  localparam logic [IW-1:0] LAST = IW'(NSLICE);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    sel;
  logic [3:0]       s_a;
  logic [3:0]       s_b;
  logic [3:0]       s_res;
  logic             s_cout;
  logic             slt;
  logic             binv;
  logic [1:0]       s_op;
  logic             ovf_raw;
  logic [WIDTH-1:0] fin;

  // Slice controls; SLT runs as a subtract.
  always_comb begin
    slt  = (ctrl_q == ALU_SLT);
    binv = slt ? 1'b1 : ctrl_q[2];
    s_op = slt ? 2'b10 : ctrl_q[1:0];
    sel  = (idx_q < LAST) ? idx_q : '0;
    s_a  = a_q[sel*SLICE_W +: SLICE_W];
    s_b  = b_q[sel*SLICE_W +: SLICE_W];
  end

  alu_4 u_slice (
    .a_i        (s_a),
    .b_i        (s_b),
    .cin_i      (carry_q),
    .a_invert_i (ctrl_q[3]),
    .b_invert_i (binv),
    .less_i     (1'b0),
    .op_i       (s_op),
    .result_o   (s_res),
    .cout_o     (s_cout)
  );

  // Signed overflow and SLT substitution on the raw sum.
  always_comb begin
    ovf_raw = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ binv)) &&
              (res_q[WIDTH-1] != a_q[WIDTH-1]);
    fin = res_q;
    if (slt) fin = {{(WIDTH-1){1'b0}}, res_q[WIDTH-1] ^ ovf_raw};
  end

  // Next-state, nibble accumulation and flag capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = src1;
          b_d     = src2;
          ctrl_d  = alu_ctrl;
          idx_d   = '0;
          carry_d = alu_ctrl[2];
          res_d   = '0;
          zero_d  = 1'b0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST) begin
          res_d   = fin;
          zero_d  = (fin == '0);
          cout_d  = is_arith(ctrl_q) ? carry_q : 1'b0;
          ovf_d   = ((ctrl_q == ALU_ADD) || (ctrl_q == ALU_SUB))
                    ? ovf_raw : 1'b0;
          state_d = ST_DONE;
        end else begin
          res_d[sel*SLICE_W +: SLICE_W] = s_res;
          carry_d = s_cout;
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (WIDTH=32).
// Hand-computed vectors, immediate-assert checks.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  int lat;

  alu_nibble_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait its accept edge, then scramble operands.
  task automatic req(input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
    alu_ctrl = c;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    src1     = 32'hDEAD_BEEF;
    src2     = 32'h1234_5678;
    alu_ctrl = ALU_OR;
  endtask

  // Count cycles to out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic z,
                     input logic co, input logic ov);
    req(c, a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_res"}, result, r);
    check({tag, "_zero"}, zero, z);
    check({tag, "_cout"}, cout, co);
    check({tag, "_ovf"}, overflow, ov);
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    src1      = '0;
    src2      = '0;
    alu_ctrl  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", overflow, 0);

    run("add", ALU_ADD, 32'h0000_000F, 32'h0000_0001,
        32'h0000_0010, 0, 0, 0);
    check("idle_after_drain", in_ready, 1);
    run("sub", ALU_SUB, 32'h8000_0000, 32'h0000_0001,
        32'h7FFF_FFFF, 0, 1, 1);
    run("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001,
        32'h0000_0001, 0, 1, 0);
    run("slt_ovf", ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000,
        32'h0000_0000, 1, 0, 0);
    run("nor", ALU_NOR, 32'h0F0F_0F0F, 32'hF0F0_0000,
        32'h0000_F0F0, 0, 0, 0);
    run("and", ALU_AND, 32'hFFFF_0000, 32'h00FF_FF00,
        32'h00FF_0000, 0, 0, 0);

    // Backpressure with a second request held pending.
    req(ALU_OR, 32'h1234_0000, 32'h0000_5678);
    wait_done(lat);
    check("bp_lat", lat, 9);
    alu_ctrl = ALU_AND;
    src1     = 32'hFFFF_FFFF;
    src2     = 32'h0000_00FF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_res", result, 32'h1234_5678);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    src1     = 32'h0;
    check("bp2_accepted", in_ready, 0);
    wait_done(lat);
    check("bp2_lat", lat, 9);
    check("bp2_res", result, 32'h0000_00FF);
    drain();

    // Reset while RUN is at nibble 3.
    req(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    tick();
    tick();
    tick();
    check("mid_busy", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_result", result, 0);
    check("mrst_cout", cout, 0);
    run("post_rst_add", ALU_ADD, 32'h2, 32'h3,
        32'h0000_0005, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
